// File: rtl/apb3_master_arbiter.sv
// apb3_master_arbiter: round-robin arbiter sharing one APB3 bus between NREQ requesters,
// with a wait-state timeout that forces an error response against a hung slave.
module apb3_master_arbiter #(
    parameter int NREQ    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ-1:0]  req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]  req_ready,
    output logic [NREQ-1:0]  rsp_valid,
    output logic [DW-1:0]    rsp_rdata,
    output logic             rsp_err,
    output logic             PSEL,
    output logic             PENABLE,
    output logic [AW-1:0]    PADDR,
    output logic             PWRITE,
    output logic [DW-1:0]    PWDATA,
    input  logic [DW-1:0]    PRDATA,
    input  logic             PREADY,
    input  logic             PSLVERR
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   last_q, last_d, gnt, cand;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            found, grant, done;
    logic            psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic [DW-1:0]   pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic            err_q, err_d;

    // Search starts just after the last winner, so the previous grantee has lowest priority.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        cand  = last_q;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == IW'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (!found && req_valid[cand]) begin
                gnt   = cand;
                found = 1'b1;
            end
        end
    end

    assign grant = (state_q == IDLE) && found;
    assign done  = (state_q == ACCESS) && (PREADY || cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = found ? SETUP : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = done ? IDLE : ACCESS;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = grant ? (NREQ'(1) << gnt) : '0;
        last_d    = grant ? gnt : last_q;
        paddr_d   = grant ? req_addr[gnt*AW +: AW] : paddr_q;
        pwdata_d  = grant ? req_wdata[gnt*DW +: DW] : pwdata_q;
        pwrite_d  = grant ? req_write[gnt] : pwrite_q;
        psel_d    = grant ? 1'b1 : done ? 1'b0 : psel_q;
        penable_d = (state_q == SETUP) ? 1'b1 : done ? 1'b0 : penable_q;
        cnt_d     = (state_q == SETUP) ? '0 : (state_q == ACCESS && !done) ? cnt_q + 1'b1 : cnt_q;
        rvalid_d  = done ? (NREQ'(1) << last_q) : '0;
        err_d     = done ? (PREADY ? PSLVERR : 1'b1) : err_q;
        // Writes never disturb the last read value.
        rdata_d   = (done && !pwrite_q) ? (PREADY ? PRDATA : DW'(32'hDEADBEEF)) : rdata_q;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            last_q    <= IW'(NREQ - 1);
            cnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rvalid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_apb3_master_arbiter.sv
// tb_apb3_master_arbiter: directed checks of arbitration, APB3 timing, timeout and reset abort
// against a small behavioural slave with programmable wait states.
module tb_apb3_master_arbiter;
    logic        PCLK, PRESETn;
    logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
    logic [63:0] req_addr, req_wdata;
    logic [31:0] rsp_rdata, PADDR, PWDATA, PRDATA;
    logic        rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

    int n_chk = 0, n_err = 0;
    int wait_n = 0, wcnt_q = 0;
    bit stuck = 0, slverr = 0;
    logic [31:0] reg0_q;

    apb3_master_arbiter dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial PCLK = 0;
    always #5 PCLK = ~PCLK;

    // Slave: address 0x4 is a read-only constant, everything else maps to one register.
    assign PREADY  = PSEL && PENABLE && !stuck && (wcnt_q >= wait_n);
    assign PSLVERR = slverr && PREADY;
    assign PRDATA  = PADDR[2] ? 32'h12345678 : reg0_q;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wcnt_q <= 0;
            reg0_q <= 32'h0;
        end else if (PSEL && PENABLE) begin
            if (PREADY) begin
                wcnt_q <= 0;
                if (PWRITE && !slverr && !PADDR[2]) reg0_q <= PWDATA;
            end else wcnt_q <= wcnt_q + 1;
        end else wcnt_q <= 0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        PRESETn = 0;
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1;
    endtask

    // One full transfer from an idle bus; reports what was seen along the way.
    task automatic xfer(input int r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        output logic [1:0] rdy, output bit setup_ok, output int rsp_cyc,
                        output int acc, output int unstable, output int pulses,
                        output logic [1:0] rv, output logic [31:0] rd, output logic e, output logic ps);
        int after;
        req_valid = 2'b01 << r;
        req_write[r] = w;
        req_addr[r*32 +: 32] = a;
        req_wdata[r*32 +: 32] = d;
        #1 rdy = req_ready;
        @(posedge PCLK);
        #1 req_valid = 0;
        setup_ok = 0; rsp_cyc = 0; acc = 0; unstable = 0; pulses = 0; after = 0;
        rv = 0; rd = 0; e = 0; ps = 1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge PCLK);
            if (i == 1) setup_ok = PSEL && !PENABLE;
            if (PSEL && PENABLE) begin
                acc++;
                if (PADDR !== a || PWRITE !== w || (w && PWDATA !== d)) unstable++;
            end
            if (rsp_valid != 0) begin
                pulses++;
                if (pulses == 1) begin
                    rsp_cyc = i; rv = rsp_valid; rd = rsp_rdata; e = rsp_err; ps = PSEL;
                end
            end
            if (pulses > 0 && ++after > 2) break;
        end
    endtask

    logic [1:0]  rdy, rv;
    logic [31:0] rd;
    logic        e, ps;
    bit          setup_ok;
    int          rsp_cyc, acc, unstable, pulses, ng, twohot, rvs;

    initial begin
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        PRESETn = 0;
        #2;
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", rsp_err, 0);
        do_reset();
        @(negedge PCLK);

        xfer(0, 0, 32'h4, 32'h0, rdy, setup_ok, rsp_cyc, acc, unstable, pulses, rv, rd, e, ps);
        check("rd_ready", rdy, 2'b01);
        check("rd_setup", setup_ok, 1);
        check("rd_latency", rsp_cyc, 3);
        check("rd_rsp_valid", rv, 2'b01);
        check("rd_rdata", rd, 32'h12345678);
        check("rd_err", e, 0);
        check("rd_pulses", pulses, 1);

        wait_n = 3;
        xfer(1, 1, 32'h0, 32'hA5A5A5A5, rdy, setup_ok, rsp_cyc, acc, unstable, pulses, rv, rd, e, ps);
        check("wr_ready", rdy, 2'b10);
        check("wr_access_cycles", acc, 4);
        check("wr_unstable", unstable, 0);
        check("wr_pulses", pulses, 1);
        check("wr_rsp_valid", rv, 2'b10);
        check("wr_rdata_kept", rd, 32'h12345678);
        wait_n = 0;
        xfer(0, 0, 32'h0, 32'h0, rdy, setup_ok, rsp_cyc, acc, unstable, pulses, rv, rd, e, ps);
        check("wr_readback", rd, 32'hA5A5A5A5);

        do_reset();
        req_write = 0; req_addr = {32'h4, 32'h4};
        req_valid = 2'b11;
        ng = 0; twohot = 0;
        for (int i = 0; i < 60 && ng < 6; i++) begin
            @(negedge PCLK);
            if (rsp_valid == 2'b11) twohot++;
            if (req_ready != 0) begin
                check("fair_grant", req_ready, (ng % 2) ? 2'b10 : 2'b01);
                ng++;
            end
        end
        @(posedge PCLK);
        #1 req_valid = 0;
        repeat (5) begin
            @(negedge PCLK);
            if (rsp_valid == 2'b11) twohot++;
        end
        check("fair_count", ng, 6);
        check("fair_twohot", twohot, 0);

        stuck = 1;
        xfer(0, 0, 32'h4, 32'h0, rdy, setup_ok, rsp_cyc, acc, unstable, pulses, rv, rd, e, ps);
        check("to_access_cycles", acc, 16);
        check("to_rsp_valid", rv, 2'b01);
        check("to_err", e, 1);
        check("to_rdata", rd, 32'hDEADBEEF);
        check("to_psel", ps, 0);
        stuck = 0;
        xfer(1, 0, 32'h4, 32'h0, rdy, setup_ok, rsp_cyc, acc, unstable, pulses, rv, rd, e, ps);
        check("after_to_rdata", rd, 32'h12345678);
        check("after_to_err", e, 0);

        slverr = 1;
        xfer(0, 1, 32'h0, 32'h11, rdy, setup_ok, rsp_cyc, acc, unstable, pulses, rv, rd, e, ps);
        check("slverr_err", e, 1);
        check("slverr_rsp_valid", rv, 2'b01);
        check("slverr_rdata_kept", rd, 32'h12345678);
        check("slverr_pulses", pulses, 1);
        slverr = 0;

        stuck = 1;
        req_valid = 2'b01; req_write = 0; req_addr[31:0] = 32'h4;
        @(posedge PCLK);
        #1 req_valid = 0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("abort_in_access", PSEL && PENABLE, 1);
        #1 PRESETn = 0;
        #1;
        check("abort_psel", PSEL, 0);
        check("abort_penable", PENABLE, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        stuck = 0;
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1;
        rvs = 0;
        repeat (3) begin
            @(negedge PCLK);
            if (rsp_valid != 0) rvs++;
        end
        check("abort_no_rsp", rvs, 0);
        req_valid = 2'b11;
        #1 check("abort_first_grant", req_ready, 2'b01);
        @(posedge PCLK);
        #1 req_valid = 0;
        repeat (4) @(posedge PCLK);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
